// File: rtl/dcm_prog_engine.sv
// Programs N_CH DCM_CLKGEN channels with clamped M/D values over a PROGEN/PROGDATA serial protocol.
// Optional build macro DCM_PROG_TIMEOUT_EN adds a PROGDONE timeout with sticky per-channel error.
module dcm_prog_engine #(
    parameter int unsigned N_CH          = 2,
    parameter int unsigned MIN_MULT      = 20,
    parameter int unsigned MAX_MULT      = 88,
    parameter int unsigned MAX_DIV       = 32,
    parameter int unsigned INITIAL_MULT  = 60,
    parameter int unsigned INITIAL_DIV   = 10,
    parameter int unsigned PROG_DIV      = 4,
    parameter int unsigned TIMEOUT_TICKS = 1024,
    localparam int unsigned CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [CH_W-1:0]   cmd_ch_i,
    input  logic [7:0]        cmd_mult_i,
    input  logic [7:0]        cmd_div_i,
    output logic [N_CH-1:0]   dcm_prog_en_o,
    output logic [N_CH-1:0]   dcm_prog_data_o,
    input  logic [N_CH-1:0]   dcm_prog_done_i,
    output logic              busy_o,
    output logic [8*N_CH-1:0] cur_mult_o,
    output logic [N_CH-1:0]   error_o
);

    localparam int unsigned DIV_W  = $clog2(PROG_DIV);
    localparam int unsigned STEP_W = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_WAIT} state_e;

    function automatic logic [7:0] clamp_mult(input logic [7:0] m);
        logic [7:0] r;
        r = m;
        if (32'(m) < MIN_MULT) r = 8'(MIN_MULT);
        else if (32'(m) > MAX_MULT) r = 8'(MAX_MULT);
        return r;
    endfunction

    function automatic logic [7:0] clamp_div(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (d == 8'd0) r = 8'd1;
        else if (32'(d) > MAX_DIV) r = 8'(MAX_DIV);
        return r;
    endfunction

    // {en,data} for one frame step: header, D-1 LSB first, gap, header, M-1 LSB first, gap, trailer
    function automatic logic [1:0] frame_bits(input logic [STEP_W-1:0] step,
                                              input logic [7:0] m1, input logic [7:0] d1);
        logic [1:0] b;
        b = 2'b00;
        if (step == 5'd0 || step == 5'd13 || step == 5'd14) b = 2'b11;
        else if (step == 5'd1 || step == 5'd25) b = 2'b10;
        else if (step >= 5'd2 && step <= 5'd9) b = {1'b1, d1[3'(step - 5'd2)]};
        else if (step >= 5'd15 && step <= 5'd22) b = {1'b1, m1[3'(step - 5'd15)]};
        return b;
    endfunction

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CH_W-1:0]   sel_q, sel_d, last_q, last_d;
    logic [7:0]        m1_q, m1_d, d1_q, d1_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [7:0]        pm_q [N_CH];
    logic [7:0]        pm_d [N_CH];
    logic [7:0]        pd_q [N_CH];
    logic [7:0]        pd_d [N_CH];
    logic [7:0]        cm_q [N_CH];
    logic [7:0]        cm_d [N_CH];
    logic [7:0]        cd_q [N_CH];
    logic [7:0]        cd_d [N_CH];
    logic [N_CH-1:0]   en_q, en_d, data_q, data_d;
    logic              busy_q, busy_d, ready_q;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              tick_c;

`ifdef DCM_PROG_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [N_CH-1:0]  err_q, err_d;
    assign error_o = err_q;
`else
    logic unused_tmo_c;
    assign unused_tmo_c = |TIMEOUT_TICKS;
    assign error_o      = '0;
`endif

    assign tick_c          = (div_cnt_q == DIV_W'(PROG_DIV - 1));
    assign cmd_ready_o     = ready_q;
    assign dcm_prog_en_o   = en_q;
    assign dcm_prog_data_o = data_q;
    assign busy_o          = busy_q;

    always_comb begin
        cur_mult_o = '0;
        for (int unsigned c = 0; c < N_CH; c++) cur_mult_o[8*c +: 8] = cm_q[c];
    end

    // Next-state: engine advances only on tick; accepted commands overwrite pending slots last
    always_comb begin
        logic              found;
        logic [CH_W-1:0]   cand;
        int unsigned       idx;
        logic [1:0]        bits;
        state_d   = state_q;
        step_d    = step_q;
        sel_d     = sel_q;
        last_d    = last_q;
        m1_d      = m1_q;
        d1_d      = d1_q;
        pend_d    = pend_q;
        pm_d      = pm_q;
        pd_d      = pd_q;
        cm_d      = cm_q;
        cd_d      = cd_q;
        en_d      = '0;
        data_d    = '0;
        bits      = 2'b00;
        found     = 1'b0;
        cand      = '0;
        idx       = 0;
        div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
`ifdef DCM_PROG_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif

        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(last_q) + k) % N_CH;
            if (!found && pend_q[CH_W'(idx)]) begin
                found = 1'b1;
                cand  = CH_W'(idx);
            end
        end

        if (tick_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        pend_d[cand] = 1'b0;
                        last_d       = cand;
                        if (pm_q[cand] != cm_q[cand] || pd_q[cand] != cd_q[cand]) begin
                            sel_d   = cand;
                            m1_d    = pm_q[cand] - 8'd1;
                            d1_d    = pd_q[cand] - 8'd1;
                            step_d  = '0;
                            state_d = ST_FRAME;
                        end
                    end
                end
                ST_FRAME: begin
                    if (step_q == STEP_W'(25)) begin
                        state_d = ST_WAIT;
`ifdef DCM_PROG_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (dcm_prog_done_i[sel_q]) begin
                        cm_d[sel_q] = m1_q + 8'd1;
                        cd_d[sel_q] = d1_q + 8'd1;
                        state_d     = ST_IDLE;
`ifdef DCM_PROG_TIMEOUT_EN
                        err_d[sel_q] = 1'b0;
                    end else if (tmo_q == TMO_W'(TIMEOUT_TICKS - 1)) begin
                        err_d[sel_q] = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (cmd_valid_i && ready_q && (32'(cmd_ch_i) < N_CH)) begin
            pm_d[cmd_ch_i]   = clamp_mult(cmd_mult_i);
            pd_d[cmd_ch_i]   = clamp_div(cmd_div_i);
            pend_d[cmd_ch_i] = 1'b1;
        end

        if (state_d == ST_FRAME) begin
            bits          = frame_bits(step_d, m1_d, d1_d);
            en_d[sel_d]   = bits[1];
            data_d[sel_d] = bits[0];
        end
        busy_d = (state_d != ST_IDLE) || (|pend_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            sel_q     <= '0;
            last_q    <= CH_W'(N_CH - 1);
            m1_q      <= '0;
            d1_q      <= '0;
            pend_q    <= '1;
            en_q      <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            div_cnt_q <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                pm_q[c] <= clamp_mult(8'(INITIAL_MULT));
                pd_q[c] <= clamp_div(8'(INITIAL_DIV));
                cm_q[c] <= '0;
                cd_q[c] <= '0;
            end
`ifdef DCM_PROG_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            m1_q      <= m1_d;
            d1_q      <= d1_d;
            pend_q    <= pend_d;
            pm_q      <= pm_d;
            pd_q      <= pd_d;
            cm_q      <= cm_d;
            cd_q      <= cd_d;
            en_q      <= en_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            ready_q   <= 1'b1;
            div_cnt_q <= div_cnt_d;
`ifdef DCM_PROG_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_dcm_prog_engine.sv
// Bench for dcm_prog_engine: decodes serial frames like a DCM would and checks them against
// a clamp/current-value model driven by directed and random commands.
module tb_dcm_prog_engine;

    localparam int unsigned PD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [0:0]  cmd_ch = '0;
    logic [7:0]  cmd_mult = '0;
    logic [7:0]  cmd_div = '0;
    logic [1:0]  en, data, err;
    logic [1:0]  dcm_done;
    logic        busy;
    logic [15:0] cur_mult;

    always #5 clk = ~clk;

    dcm_prog_engine #(
        .N_CH(2), .MIN_MULT(20), .MAX_MULT(88), .MAX_DIV(32),
        .INITIAL_MULT(60), .INITIAL_DIV(10), .PROG_DIV(PD), .TIMEOUT_TICKS(8)
    ) dut (
        .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_ch_i(cmd_ch), .cmd_mult_i(cmd_mult), .cmd_div_i(cmd_div),
        .dcm_prog_en_o(en), .dcm_prog_data_o(data), .dcm_prog_done_i(dcm_done),
        .busy_o(busy), .cur_mult_o(cur_mult), .error_o(err)
    );

    typedef struct {
        int         ch;
        logic [7:0] m1;
        logic [7:0] d1;
        bit         ok;
    } frame_t;

    frame_t     obs[$];
    int         checks = 0;
    int         failures = 0;
    int         pcnt = 0;
    int         fidx [2] = '{-1, -1};
    int         hold [2] = '{0, 0};
    int         started = 0;
    logic [1:0] fbuf [2][26];
    bit   [1:0] auto_done = 2'b11;
    int         cur_m [2];
    int         cur_d [2];

    function automatic int clamp_m(input int m);
        return (m < 20) ? 20 : ((m > 88) ? 88 : m);
    endfunction

    function automatic int clamp_d(input int d);
        return (d < 1) ? 1 : ((d > 32) ? 32 : d);
    endfunction

    // Expected {en,data} of frame step s given the D-1 and M-1 bytes it carries
    function automatic logic [1:0] frame_ref(input int s, input logic [7:0] m1, input logic [7:0] d1);
        logic [7:0] t;
        if (s == 0 || s == 13 || s == 14) return 2'b11;
        if (s == 1 || s == 25) return 2'b10;
        if (s >= 2 && s <= 9) begin t = d1 >> (s - 2); return {1'b1, t[0]}; end
        if (s >= 15 && s <= 22) begin t = m1 >> (s - 15); return {1'b1, t[0]}; end
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // DCM-side monitor: samples once per tick, collects 26-step frames, answers with PROGDONE
    always @(posedge clk) begin : mon
        bit         tk;
        logic [1:0] v;
        logic [7:0] m1, d1;
        bit         ok;
        tk   = !reset && (pcnt == PD - 1);
        pcnt = (reset || tk) ? 0 : pcnt + 1;
        #1;
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                fidx[c]     = -1;
                hold[c]     = 0;
                dcm_done[c] = 1'b0;
            end else begin
                if (hold[c] > 0) begin
                    hold[c]--;
                    if (hold[c] == 0) dcm_done[c] = 1'b0;
                end
                if (tk) begin
                    v = {en[c], data[c]};
                    if (fidx[c] < 0) begin
                        if (v[1]) begin
                            fbuf[c][0] = v;
                            fidx[c]    = 1;
                            started++;
                        end
                    end else if (fidx[c] < 26) begin
                        fbuf[c][fidx[c]] = v;
                        fidx[c]++;
                    end else begin
                        for (int b = 0; b < 8; b++) begin
                            d1[b] = fbuf[c][2 + b][0];
                            m1[b] = fbuf[c][15 + b][0];
                        end
                        ok = (v == 2'b00) && ({en[1-c], data[1-c]} == 2'b00);
                        for (int s = 0; s < 26; s++)
                            if (fbuf[c][s] != frame_ref(s, m1, d1)) ok = 1'b0;
                        obs.push_back('{ch: c, m1: m1, d1: d1, ok: ok});
                        fidx[c] = -1;
                        if (auto_done[c]) begin
                            dcm_done[c] = 1'b1;
                            hold[c]     = PD;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int ch, input int m, input int d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ch    = 1'(ch);
        cmd_mult  = 8'(m);
        cmd_div   = 8'(d);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic exp_frame(input int ch, input int m1, input int d1);
        frame_t f;
        int     n = 0;
        while (obs.size() == 0 && n < 1500) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("frame_seen", 32'(obs.size() != 0), 32'd1);
        if (obs.size() != 0) begin
            f = obs.pop_front();
            check("frame_ch", 32'(f.ch), 32'(ch));
            check("frame_m1", 32'(f.m1), 32'(m1));
            check("frame_d1", 32'(f.d1), 32'(d1));
            check("frame_shape", 32'(f.ok), 32'd1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 1500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic prog(input int ch, input int m, input int d);
        int cm, cd;
        cm = clamp_m(m);
        cd = clamp_d(d);
        send(ch, m, d);
        wait_idle();
        if (cm == cur_m[ch] && cd == cur_d[ch]) begin
            check("skip_no_frame", 32'(obs.size()), 32'd0);
        end else begin
            exp_frame(ch, cm - 1, cd - 1);
            cur_m[ch] = cm;
            cur_d[ch] = cd;
        end
        check("cur_mult", 32'(cur_mult), 32'((cur_m[1] << 8) | cur_m[0]));
    endtask

    initial begin : main
        int n, st, ch, m, d;
        repeat (3) @(posedge clk);
        #2;
        check("rst_en", 32'(en), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cur_mult", 32'(cur_mult), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Power-on programming of both channels, ch0 first
        exp_frame(0, 59, 9);
        exp_frame(1, 59, 9);
        wait_idle();
        cur_m = '{60, 60};
        cur_d = '{10, 10};
        check("init_cur_mult", 32'(cur_mult), 32'h3c3c);
        check("init_err", 32'(err), 32'd0);
        check("ready_hi", 32'(cmd_ready), 32'd1);

        // Same values as programmed: no frame, busy drops on the next tick
        st = started;
        send(0, 60, 10);
        check("skip_busy_hi", 32'(busy), 32'd1);
        repeat (2 * PD) @(posedge clk);
        #2;
        check("skip_busy_lo", 32'(busy), 32'd0);
        repeat (40) @(posedge clk);
        #2;
        check("skip_no_start", 32'(started), 32'(st));

        // Clamp at both ends
        prog(1, 200, 0);
        check("clamp_hi_mult", 32'(cur_mult[15:8]), 32'd88);

        // Overwrite while ch0's frame runs: both values are programmed in order
        send(0, 40, 10);
        n = 0;
        while (en[0] !== 1'b1 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("frame_started", 32'(en[0]), 32'd1);
        send(0, 50, 10);
        exp_frame(0, 39, 9);
        exp_frame(0, 49, 9);
        wait_idle();
        cur_m[0] = 50;
        check("overwrite_cur_mult", 32'(cur_mult[7:0]), 32'd50);

        // Random commands, some repeating the current values
        for (int i = 0; i < 12; i++) begin
            ch = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                m = cur_m[ch];
                d = cur_d[ch];
            end else begin
                m = int'($urandom_range(0, 255));
                d = int'($urandom_range(0, 255));
            end
            prog(ch, m, d);
        end

`ifdef DCM_PROG_TIMEOUT_EN
        // PROGDONE withheld on ch1: error after the timeout, ch0 still programmable
        auto_done = 2'b01;
        m = (cur_m[1] == 70) ? 71 : 70;
        send(1, m, 10);
        exp_frame(1, m - 1, 9);
        n = 0;
        while (err[1] !== 1'b1 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("tmo_err", 32'(err), 32'd2);
        check("tmo_cur_mult", 32'(cur_mult[15:8]), 32'(cur_m[1]));
        auto_done = 2'b11;
        m = (cur_m[0] == 45) ? 46 : 45;
        prog(0, m, 10);
        check("tmo_err_sticky", 32'(err), 32'd2);
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        // Reset in the middle of a frame (step 12) abandons it
        m = (cur_m[1] == 30) ? 31 : 30;
        send(1, m, 5);
        n = 0;
        while (fidx[1] != 13 && n < 1500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("mid_step12", 32'(fidx[1]), 32'd13);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("mid_rst_en", 32'(en), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_cur", 32'(cur_mult), 32'd0);
        repeat (2) @(negedge clk);
        obs.delete();
        reset = 1'b0;
        exp_frame(0, 59, 9);
        exp_frame(1, 59, 9);
        wait_idle();
        check("rerst_cur_mult", 32'(cur_mult), 32'h3c3c);
        check("rerst_err", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcm_prog_engine.md
DCM_PROG_ENGINE -- requirements
Module: dcm_prog_engine

Interface
REQ-001 Parameter N_CH, default 2: number of independently programmed DCM_CLKGEN channels (1..8).
REQ-002 Parameter MIN_MULT, default 20 / MAX_MULT, default 88: inclusive multiplier clamp range.
REQ-003 Parameter MAX_DIV, default 32: inclusive upper divider clamp; lower bound fixed at 1.
REQ-004 Parameter INITIAL_MULT, default 60 / INITIAL_DIV, default 10: values programmed after reset.
REQ-005 Parameter PROG_DIV, default 4: clk cycles per programming tick (2..255).
REQ-006 Parameter TIMEOUT_TICKS, default 1024: ticks allowed for dcm_prog_done (timeout build only).
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 cmd_valid  in  1  command request; accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-010 cmd_ready  out  1  constant 1 outside reset; low during reset.
REQ-011 cmd_ch  in  clog2(N_CH), min 1  target channel; values >= N_CH are dropped silently.
REQ-012 cmd_mult  in  8  requested multiplier M.
REQ-013 cmd_div  in  8  requested divider D.
REQ-014 dcm_prog_en  out  N_CH  per-channel PROGEN.
REQ-015 dcm_prog_data  out  N_CH  per-channel PROGDATA.
REQ-016 dcm_prog_done  in  N_CH  per-channel PROGDONE, synchronous to clk.
REQ-017 busy  out  1  high while any frame is in progress or any pending flag is set.
REQ-018 cur_mult  out  8*N_CH  last multiplier confirmed by PROGDONE, channel c at bits [8c+7:8c].
REQ-019 error  out  N_CH  sticky per-channel programming-timeout flag.

Function
REQ-020 Accepted commands clamp M to [MIN_MULT,MAX_MULT] and D to [1,MAX_DIV], store them in the channel's pending slot, and set its pending flag.
REQ-021 A later command to the same channel overwrites the pending slot (last write wins), including while that channel's frame runs; the running frame is unaffected.
REQ-022 A tick strobe fires every PROG_DIV clk cycles from a free-running counter; all engine state changes occur only on tick.
REQ-023 Engine states: IDLE, FRAME (step 0..25), WAIT (step 26).
REQ-024 In IDLE on tick, select a pending channel round-robin starting at (last served + 1) mod N_CH; clear its pending flag; latch M-1 and D-1; enter FRAME step 0.
REQ-025 If the selected channel's pending M and D equal its current programmed values, clear the pending flag and remain IDLE (no frame).
REQ-026 Per step, selected channel {en,data}: 0:11, 1:10, 2-9: en 1, data = D-1 bits 0..7 LSB first; 10-12:00; 13-14:11; 15-22: en 1, data = M-1 bits 0..7 LSB first; 23-24:00; 25:10; 26:00.
REQ-027 Non-selected channels hold {en,data}=00 at all times.
REQ-028 In WAIT, dcm_prog_done[sel] sampled high on a tick updates cur_mult and stored current divider for sel, clears error[sel], and returns to IDLE.
REQ-029 Frame latency from selection to step 25 is exactly 26 ticks; IDLE dwell between frames is at least one tick.
REQ-030 A command arriving on the same edge as a pending-flag clear for that channel leaves the flag set with the new values.

Reset
REQ-031 Reset: dcm_prog_en=0, dcm_prog_data=0, error=0, cur_mult=0, current dividers=0, tick counter=0, state IDLE, last served = N_CH-1.
REQ-032 Reset loads every pending slot with INITIAL_MULT/INITIAL_DIV (clamped) and sets all pending flags, so each channel is programmed after reset.
REQ-033 Reset mid-frame abandons the frame; outputs are low on the first edge with reset asserted.

Configuration
REQ-034 Macro DCM_PROG_TIMEOUT_EN defined: WAIT counts ticks; on reaching TIMEOUT_TICKS without PROGDONE, set error[sel], leave cur_mult unchanged, return to IDLE.
REQ-035 Macro DCM_PROG_TIMEOUT_EN undefined: WAIT persists until PROGDONE; error is tied to 0.

Verification
REQ-036 Reset, PROG_DIV=4, done returned at step 26 -> ch0 then ch1 programmed with M-1=59, D-1=9 bit patterns; cur_mult=60 on both.
REQ-037 cmd ch1 M=200 D=0 -> frame carries M-1=87, D-1=0; cur_mult[15:8]=88.
REQ-038 cmd ch0 M=40 then M=50 during ch0 frame -> current frame completes with 40, then second frame with 50; final cur_mult[7:0]=50.
REQ-039 cmd ch0 M=60 D=10 after initial programming -> no frame, busy drops next tick.
REQ-040 DCM_PROG_TIMEOUT_EN, TIMEOUT_TICKS=8, done never asserted on ch1 -> error[1]=1 after 8 WAIT ticks, ch0 still serviceable.
REQ-041 Reset asserted at step 12 -> outputs 00 next edge; both channels reprogrammed with initial values after release.
